// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : controller states IDLE / SHIFT / DONE
//   DEFAULT_WIDTH : default operand width in bits
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs_nand.sv
// 1-bit full subtractor built only from 2-input NAND gates.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   diff : a ^ b ^ bin
//   bout : (~a & b) | (~(a ^ b) & bin)
module fs_nand (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic n1, n2, n3, x;
   logic m1, m2, m3;

   // First XOR stage: x = a ^ b. The n3 term equals ~(~a & b).
   assign n1 = ~(a & b);
   assign n2 = ~(a & n1);
   assign n3 = ~(b & n1);
   assign x  = ~(n2 & n3);

   // Second XOR stage: diff = x ^ bin. The m3 term equals ~(~x & bin).
   assign m1   = ~(x & bin);
   assign m2   = ~(x & m1);
   assign m3   = ~(bin & m1);
   assign diff = ~(m2 & m3);

   // bout = (~a & b) | (~x & bin) = NAND of the two complemented terms.
   assign bout = ~(n3 & m3);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset, priority over start
//   start : begin a subtraction (accepted in IDLE or DONE only)
//   a, b  : operands, captured on an accepted start
//   busy  : high while bits are being processed (SHIFT)
//   done  : one-cycle pulse when diff/bout/ovf are fresh (DONE)
//   diff  : a - b modulo 2^WIDTH
//   bout  : final borrow, 1 when unsigned a < b
//   ovf   : two's-complement overflow of a - b
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               br_q, br_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               amsb_q, amsb_d;
   logic               bmsb_q, bmsb_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               ovf_q, ovf_d;

   logic               cell_diff;
   logic               cell_bout;

   fs_nand u_cell (
      .a    (opa_q[0]),
      .b    (opb_q[0]),
      .bin  (br_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = SHIFT;
               opa_d   = a;
               opb_d   = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               // Sign bits are kept aside because the operand registers
               // are shifted away by the time overflow is evaluated.
               amsb_d  = a[WIDTH-1];
               bmsb_d  = b[WIDTH-1];
            end
         end
         SHIFT: begin
            res_d = {cell_diff, res_q[WIDTH-1:1]};
            opa_d = opa_q >> 1;
            opb_d = opb_q >> 1;
            br_d  = cell_bout;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               // Visible results change only here, so they hold through
               // any following operation until its own completion.
               diff_d  = {cell_diff, res_q[WIDTH-1:1]};
               bout_d  = cell_bout;
               ovf_d   = (amsb_q ^ bmsb_q) & (cell_diff ^ amsb_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction a-b.
REQ-005 SHALL have port a  input  WIDTH  minuend, sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, sampled only on an accepted start.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  single-cycle pulse when the result is valid.
REQ-009 SHALL have port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  final borrow out; 1 when unsigned a<b.
REQ-011 SHALL have port ovf  output  1  two's-complement signed overflow of a-b.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in SHIFT is ignored and does not affect the operation in progress.
REQ-014 On accepted start, SHALL load a and b into shift registers, clear the internal borrow, clear the bit counter and enter SHIFT.
REQ-015 In each SHIFT cycle, SHALL process the LSB of each shift register: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-016 In each SHIFT cycle, SHALL shift d into the result register from the MSB end and shift both operand registers right by one.
REQ-017 SHALL stay in SHIFT for exactly WIDTH cycles, counted by a counter of $clog2(WIDTH)+1 bits, then enter DONE.
REQ-018 Latency: start sampled in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1 only.
REQ-019 diff, bout and ovf SHALL update only on the SHIFT->DONE transition and SHALL hold until the next such transition.
REQ-020 ovf SHALL be 1 iff a[WIDTH-1]!=b[WIDTH-1] and diff[WIDTH-1]!=a[WIDTH-1], using the captured operands.
REQ-021 DONE SHALL last one cycle; next state SHALL be SHIFT if start=1 in that cycle (back-to-back operation), else IDLE.
REQ-022 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE).
REQ-023 Changes on a or b after capture SHALL not affect the result.

Reset
REQ-024 With rst=1 at a rising edge, SHALL go to IDLE and clear busy, done, diff, bout, ovf, borrow, counter and shift registers to 0.
REQ-025 rst SHALL take priority over start.
REQ-026 rst asserted mid-SHIFT SHALL abort the operation with no done pulse, and the outputs SHALL read 0.

Structure
REQ-027 Shared package sub_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the constant DEFAULT_WIDTH=8.
REQ-028 The per-bit cell SHALL be a sub-module fs_nand, a 1-bit full subtractor (a, b, bin -> diff, bout) built from NAND gates, with one instance in serial_subtractor.
REQ-029 Only the fs_nand cell SHALL be combinational; all other logic SHALL be registered on clk.

Verification
REQ-030 The bench SHALL apply WIDTH=8, a=8'h05, b=8'h03, start for 1 cycle -> done in cycle 9 with diff=8'h02, bout=0, ovf=0.
REQ-031 The bench SHALL apply a=8'h03, b=8'h05 -> diff=8'hFE, bout=1, ovf=0.
REQ-032 The bench SHALL apply a=8'h80, b=8'h01 -> diff=8'h7F, bout=0, ovf=1; and a=8'h00, b=8'h00 -> diff=8'h00, bout=0, ovf=0.
REQ-033 The bench SHALL pulse start again mid-SHIFT with different operands -> the first result is unchanged and no extra done pulse occurs; then hold start=1 through DONE -> a second operation starts immediately and its done follows WIDTH+1 cycles later.
REQ-034 The bench SHALL assert rst in SHIFT cycle 4 -> next cycle state=IDLE, busy=0, diff=0, no done pulse; then a new start completes normally.
